// File: rtl/apb_pkg.sv
// Shared types for the APB4 requester: FSM states and command/response records.
package apb_pkg;

   localparam int unsigned APB_DATA_W = 32;
   localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

   localparam logic [2:0] APB_PROT_DEFAULT = 3'b000;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      RESP
   } apb_state_e;

   // Address is held separately because its width is set per instance.
   typedef struct packed {
      logic                  write;
      logic [APB_DATA_W-1:0] wdata;
      logic [APB_STRB_W-1:0] strb;
      logic [2:0]            prot;
   } apb_cmd_t;

   typedef struct packed {
      logic [APB_DATA_W-1:0] rdata;
      logic                  err;
      logic                  timeout;
   } apb_rsp_t;

endpackage

// File: rtl/apb_master.sv
// APB4 requester: one transfer at a time from a valid/ready command port,
// with an optional pready timeout so a hung slave cannot stall the requester.
module apb_master
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    pclk,
   input  logic                    presetn,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic                    cmd_write,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_strb,
   input  logic [2:0]              cmd_prot,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic                    rsp_err,
   output logic                    rsp_timeout,
   output logic [ADDR_WIDTH-1:0]   paddr,
   output logic [2:0]              pprot,
   output logic                    psel,
   output logic                    penable,
   output logic                    pwrite,
   output logic [DATA_WIDTH-1:0]   pwdata,
   output logic [DATA_WIDTH/8-1:0] pstrb,
   input  logic [DATA_WIDTH-1:0]   prdata,
   input  logic                    pready,
   input  logic                    pslverr
);

   localparam int unsigned CNT_W =
      (TIMEOUT_CYCLES > 0) ? (($clog2(TIMEOUT_CYCLES + 1) > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1) : 1;
   localparam bit             TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] CNT_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

   apb_state_e            state_q;
   apb_cmd_t              cmd_q;
   apb_rsp_t              rsp_q;
   logic [ADDR_WIDTH-1:0] paddr_q;
   logic [CNT_W-1:0]      cnt_q;
   logic                  cmd_ready_q;
   logic                  psel_q;
   logic                  penable_q;
   logic                  rsp_valid_q;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state_q     <= IDLE;
         cmd_q       <= '{write: 1'b0, wdata: '0, strb: '0, prot: APB_PROT_DEFAULT};
         rsp_q       <= '0;
         paddr_q     <= '0;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b0;
         psel_q      <= 1'b0;
         penable_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               cmd_ready_q <= 1'b1;
               if (cmd_valid && cmd_ready_q) begin
                  paddr_q     <= cmd_addr;
                  cmd_q.write <= cmd_write;
                  cmd_q.wdata <= APB_DATA_W'(cmd_wdata);
                  cmd_q.strb  <= cmd_write ? APB_STRB_W'(cmd_strb) : '0;
                  cmd_q.prot  <= cmd_prot;
                  cmd_ready_q <= 1'b0;
                  psel_q      <= 1'b1;
                  state_q     <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               // pready takes priority over a timeout firing in the same cycle.
               if (pready) begin
                  rsp_q.rdata   <= cmd_q.write ? '0 : APB_DATA_W'(prdata);
                  rsp_q.err     <= pslverr;
                  rsp_q.timeout <= 1'b0;
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  cnt_q         <= '0;
                  state_q       <= RESP;
               end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                  rsp_q.rdata   <= '0;
                  rsp_q.err     <= 1'b1;
                  rsp_q.timeout <= 1'b1;
                  psel_q        <= 1'b0;
                  penable_q     <= 1'b0;
                  rsp_valid_q   <= 1'b1;
                  cnt_q         <= '0;
                  state_q       <= RESP;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready   = cmd_ready_q;
   assign rsp_valid   = rsp_valid_q;
   assign rsp_rdata   = DATA_WIDTH'(rsp_q.rdata);
   assign rsp_err     = rsp_q.err;
   assign rsp_timeout = rsp_q.timeout;
   assign paddr       = paddr_q;
   assign pprot       = cmd_q.prot;
   assign psel        = psel_q;
   assign penable     = penable_q;
   assign pwrite      = cmd_q.write;
   assign pwdata      = DATA_WIDTH'(cmd_q.wdata);
   assign pstrb       = (DATA_WIDTH/8)'(cmd_q.strb);

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_apb_master;

   localparam int unsigned TO = 8;

   logic        pclk = 1'b0;
   logic        presetn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_strb;
   logic [2:0]  cmd_prot;
   logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
   logic [31:0] rsp_rdata;
   logic [31:0] paddr, pwdata, prdata;
   logic [2:0]  pprot;
   logic [3:0]  pstrb;
   logic        psel, penable, pwrite, pready, pslverr;

   int checks = 0;
   int errors = 0;

   always #5 pclk = ~pclk;

   apb_master #(
      .ADDR_WIDTH    (32),
      .DATA_WIDTH    (32),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .pclk       (pclk),
      .presetn    (presetn),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_addr   (cmd_addr),
      .cmd_write  (cmd_write),
      .cmd_wdata  (cmd_wdata),
      .cmd_strb   (cmd_strb),
      .cmd_prot   (cmd_prot),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .rsp_timeout(rsp_timeout),
      .paddr      (paddr),
      .pprot      (pprot),
      .psel       (psel),
      .penable    (penable),
      .pwrite     (pwrite),
      .pwdata     (pwdata),
      .pstrb      (pstrb),
      .prdata     (prdata),
      .pready     (pready),
      .pslverr    (pslverr)
   );

   function automatic void cmp(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: m_t counts cycles since acceptance (1 = setup, k+1 = k-th access cycle).
   bit          m_ready, m_xfer, m_rv, m_err, m_to, m_write;
   int          m_t;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_strb;
   logic [2:0]  m_prot;

   always @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         m_ready <= 0; m_xfer <= 0; m_rv <= 0; m_err <= 0; m_to <= 0; m_write <= 0;
         m_t <= 0; m_addr <= '0; m_wdata <= '0; m_rdata <= '0; m_strb <= '0; m_prot <= '0;
      end else if (m_rv) begin
         if (rsp_ready) begin
            m_rv    <= 0;
            m_ready <= 1;
         end
      end else if (m_xfer) begin
         if (m_t >= 2 && pready) begin
            m_xfer  <= 0;
            m_rv    <= 1;
            m_err   <= pslverr;
            m_to    <= 0;
            m_rdata <= m_write ? 32'h0 : prdata;
         end else if (m_t >= 2 && (m_t - 1) == int'(TO)) begin
            m_xfer  <= 0;
            m_rv    <= 1;
            m_err   <= 1;
            m_to    <= 1;
            m_rdata <= 32'h0;
         end else begin
            m_t <= m_t + 1;
         end
      end else if (m_ready && cmd_valid) begin
         m_ready <= 0;
         m_xfer  <= 1;
         m_t     <= 1;
         m_write <= cmd_write;
         m_addr  <= cmd_addr;
         m_wdata <= cmd_wdata;
         m_strb  <= cmd_write ? cmd_strb : 4'h0;
         m_prot  <= cmd_prot;
      end else begin
         m_ready <= 1;
      end
   end

   always @(negedge pclk) begin
      cmp("cmd_ready", cmd_ready, m_ready);
      cmp("psel", psel, m_xfer);
      cmp("penable", penable, m_xfer && m_t >= 2);
      cmp("rsp_valid", rsp_valid, m_rv);
      cmp("paddr", paddr, m_addr);
      cmp("pwrite", pwrite, m_write);
      cmp("pwdata", pwdata, m_wdata);
      cmp("pstrb", pstrb, m_strb);
      cmp("pprot", pprot, m_prot);
      if (m_rv) begin
         cmp("rsp_rdata", rsp_rdata, m_rdata);
         cmp("rsp_err", rsp_err, m_err);
         cmp("rsp_timeout", rsp_timeout, m_to);
      end
   end

   task automatic tick();
      @(posedge pclk);
      #2;
   endtask

   int n;

   initial begin
      presetn = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
      cmd_strb = '0; cmd_prot = '0; rsp_ready = 0; prdata = '0; pready = 0; pslverr = 0;
      #1 presetn = 0;
      #2;
      cmp("rst_psel", psel, 0);
      cmp("rst_cmd_ready", cmd_ready, 0);
      cmp("rst_rsp_valid", rsp_valid, 0);
      repeat (3) @(posedge pclk);
      #2 presetn = 1;
      tick(); tick();
      cmp("idle_cmd_ready", cmd_ready, 1);

      // Zero-wait write
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h4; cmd_wdata = 32'hDEAD_BEEF;
      cmd_strb = 4'hF; cmd_prot = 3'b010; pready = 1; rsp_ready = 1;
      tick();
      cmp("t1_setup_psel", psel, 1);
      cmp("t1_setup_penable", penable, 0);
      cmp("t1_setup_paddr", paddr, 32'h4);
      cmp("t1_setup_pwdata", pwdata, 32'hDEAD_BEEF);
      cmd_valid = 0; cmd_addr = $urandom; cmd_wdata = $urandom;
      tick();
      cmp("t1_access_penable", penable, 1);
      cmp("t1_access_paddr", paddr, 32'h4);
      cmp("t1_access_pwdata", pwdata, 32'hDEAD_BEEF);
      tick();
      cmp("t1_rsp_valid", rsp_valid, 1);
      cmp("t1_rsp_err", rsp_err, 0);
      cmp("t1_rsp_rdata", rsp_rdata, 32'h0);
      cmp("t1_rsp_psel", psel, 0);
      tick();
      cmp("t1_idle_ready", cmd_ready, 1);

      // Read with 3 wait states
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h8; cmd_strb = 4'hF;
      pready = 0; prdata = 32'hCAFE_0000;
      tick();
      cmp("t2_setup_pstrb", pstrb, 4'h0);
      cmd_valid = 0;
      tick();
      n = 0;
      while (n < 20 && penable === 1'b1) begin
         n++;
         cmp("t2_access_pstrb", pstrb, 4'h0);
         pready = (n == 4);
         prdata = (n == 4) ? 32'h1234_5678 : 32'hCAFE_0000 + n;
         tick();
      end
      pready = 0;
      cmp("t2_access_cycles", n, 4);
      cmp("t2_rsp_valid", rsp_valid, 1);
      cmp("t2_rsp_rdata", rsp_rdata, 32'h1234_5678);
      cmp("t2_rsp_err", rsp_err, 0);
      tick();

      // Write with pslverr, response back-pressured while next command waits
      cmd_valid = 1; cmd_write = 1; cmd_addr = 32'hC; cmd_wdata = 32'h5555_AAAA;
      pready = 1; pslverr = 1; rsp_ready = 0;
      tick();
      cmd_addr = 32'h10; cmd_wdata = 32'h0101_0101;
      tick(); tick();
      cmp("t3_rsp_valid", rsp_valid, 1);
      cmp("t3_rsp_err", rsp_err, 1);
      cmp("t3_rsp_timeout", rsp_timeout, 0);
      pslverr = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         cmp("t3_hold_cmd_ready", cmd_ready, 0);
         cmp("t3_hold_psel", psel, 0);
         cmp("t3_hold_rsp_err", rsp_err, 1);
      end
      rsp_ready = 1;
      tick();
      cmp("t3_release_rsp_valid", rsp_valid, 0);
      cmp("t3_release_cmd_ready", cmd_ready, 1);
      tick();
      cmp("t3_next_psel", psel, 1);
      cmp("t3_next_paddr", paddr, 32'h10);
      cmd_valid = 0;
      tick(); tick(); tick();

      // Timeout, then completion on the last permitted cycle
      for (int rep = 0; rep < 2; rep++) begin
         cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h20; pready = 0; prdata = 32'hAAAA_5555;
         tick();
         cmd_valid = 0;
         tick();
         n = 0;
         while (n < 20 && penable === 1'b1) begin
            n++;
            pready = (rep == 1) && (n == int'(TO));
            tick();
         end
         pready = 0;
         cmp("t4_access_cycles", n, TO);
         cmp("t4_psel", psel, 0);
         cmp("t4_rsp_valid", rsp_valid, 1);
         cmp("t4_rsp_timeout", rsp_timeout, (rep == 0) ? 1 : 0);
         cmp("t4_rsp_err", rsp_err, (rep == 0) ? 1 : 0);
         cmp("t4_rsp_rdata", rsp_rdata, (rep == 0) ? 32'h0 : 32'hAAAA_5555);
         tick();
      end

      // Asynchronous reset during ACCESS
      cmd_valid = 1; cmd_write = 0; cmd_addr = 32'h30; pready = 0;
      tick();
      cmd_valid = 0;
      tick(); tick();
      cmp("t5_in_access", penable, 1);
      #1 presetn = 0;
      #1;
      cmp("t5_rst_psel", psel, 0);
      cmp("t5_rst_penable", penable, 0);
      cmp("t5_rst_rsp_valid", rsp_valid, 0);
      @(posedge pclk);
      #2 presetn = 1;
      tick(); tick();
      cmp("t5_post_cmd_ready", cmd_ready, 1);
      cmd_valid = 1; cmd_addr = 32'h40; pready = 1; prdata = 32'h0BAD_F00D;
      tick();
      cmd_valid = 0;
      tick(); tick();
      cmp("t5_read_valid", rsp_valid, 1);
      cmp("t5_read_rdata", rsp_rdata, 32'h0BAD_F00D);
      tick();

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cmd_valid = $urandom_range(0, 1);
         cmd_write = $urandom_range(0, 1);
         cmd_addr  = $urandom;
         cmd_wdata = $urandom;
         cmd_strb  = 4'($urandom);
         cmd_prot  = 3'($urandom);
         rsp_ready = ($urandom_range(0, 3) != 0);
         pready    = (i < 1500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         prdata    = $urandom;
         pslverr   = $urandom_range(0, 1);
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
- APB4 initiator (requester) bridging a simple valid/ready command/response interface onto an APB bus.
- Drives APB slaves such as the GPIO APB slave from an on-chip controller, a test sequencer or a debug bridge.
- One transfer in flight at a time.
- Optional pready timeout guarantees forward progress against a hung slave.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr and paddr.
- DATA_WIDTH, 32, width of write/read data (must be 32; pstrb is DATA_WIDTH/8).
- TIMEOUT_CYCLES, 255, maximum ACCESS cycles waiting for pready; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock; all logic on rising edge.
- presetn  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  ADDR_WIDTH  target byte address.
- cmd_write  in  1  1=write, 0=read.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- cmd_prot  in  3  protection attributes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts).
- rsp_err  out  1  pslverr sampled, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- paddr  out  ADDR_WIDTH  APB address.
- pprot  out  3  APB protection.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes.
- prdata  in  DATA_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB error.

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Reset is asynchronous and active-low on presetn, clocked by pclk; psel/penable drop immediately on assert, including mid-transfer, and no response is generated.
- FSM states: IDLE, SETUP, ACCESS, RESP. All outputs are registered.
- IDLE: cmd_ready=1, psel=0, penable=0. On cmd_valid:
  - Latch addr/write/wdata/prot.
  - Latch pstrb = cmd_write ? cmd_strb : 0 (APB4: reads carry zero strobes).
  - Go to SETUP.
- SETUP (exactly 1 cycle): psel=1, penable=0, cmd_ready=0. Then ACCESS.
- ACCESS: psel=1, penable=1.
  - If pready=1: capture rsp_rdata = pwrite ? 0 : prdata, rsp_err = pslverr, rsp_timeout = 0. Go to RESP with psel=penable=0.
  - If pready=0: counter++.
  - If TIMEOUT_CYCLES != 0 and counter reaches TIMEOUT_CYCLES-1 with pready still 0: abort. Set psel=penable=0, rsp_rdata=0, rsp_err=1, rsp_timeout=1. Go to RESP.
  - Counter clears on leaving ACCESS. Counter width is clog2(TIMEOUT_CYCLES+1), minimum 1.
- pready and pslverr are ignored outside ACCESS.
- RESP: rsp_valid=1; rsp_* are stable until rsp_ready. On handshake go to IDLE with rsp_valid=0. No new command is accepted until the response is consumed.
- Stability: paddr, pwrite, pwdata, pstrb and pprot hold from SETUP through ACCESS completion. After completion they hold their last value (not zeroed) to save toggles.
- Latency with zero-wait slave and rsp_ready=1: command accepted at edge N, SETUP N+1, ACCESS N+2, rsp_valid N+3, IDLE N+4. Throughput is 1 transfer per 4 cycles.
- Timeout abort takes exactly TIMEOUT_CYCLES ACCESS cycles.
- If pready=1 in the same cycle the timeout would fire, pready wins (normal completion).

Decomposition:
- Package apb_pkg holds:
  - the FSM state enum (apb_state_e: IDLE, SETUP, ACCESS, RESP);
  - the command struct (apb_cmd_t) and response struct (apb_rsp_t);
  - the APB_PROT_DEFAULT constant (3'b000).
- Single module; no sub-module needed. The timeout counter is inline.

Test Plan:
- Write addr=0x0000_0004, wdata=0xDEAD_BEEF, strb=4'hF, pready tied 1 → psel rises N+1, penable N+2 with paddr/pwdata stable; rsp_valid at N+3, rsp_err=0, rsp_rdata=0.
- Read addr=0x0000_0008, slave inserts 3 wait states, prdata=0x1234_5678 on the pready cycle → ACCESS lasts 4 cycles, pstrb=0 throughout; rsp_rdata=0x1234_5678, rsp_err=0.
- Write with pslverr=1 alongside pready → rsp_err=1, rsp_timeout=0; the next command is accepted only after rsp_ready.
- TIMEOUT_CYCLES=8, pready held 0 → penable high for exactly 8 cycles, then psel=penable=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready=1 on the 8th cycle → normal completion.
- rsp_ready held 0 for 5 cycles with cmd_valid asserted → rsp_* stable, cmd_ready=0, no psel. Then release: IDLE, and the next command starts SETUP 1 cycle after acceptance.
- presetn asserted during ACCESS → psel/penable/rsp_valid go 0 asynchronously; after release, cmd_ready=1 and a fresh read completes correctly.
